// File: rtl/sc_b2p_arbiter.sv
// sc_b2p_arbiter: round-robin arbiter in front of a single binary-to-pulse
// stochastic converter (16-bit LFSR + unsigned greater-than compare).
// Each accepted request produces STREAM_LEN pulses tagged with the
// requester id; the LFSR restarts from SEED for every stream so identical
// inputs give identical bitstreams. The ones count is reported at the end.
`timescale 1ns/1ps
module sc_b2p_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          DATA_W     = 16,
  parameter int          STREAM_LEN = 256,
  parameter int          CNT_W      = 9,
  parameter int          ID_W       = 2,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      pulse_out,
  output logic                      pulse_valid,
  output logic [ID_W-1:0]           pulse_id,
  output logic                      pulse_last,
  output logic                      done_valid,
  output logic [CNT_W-1:0]          ones_count,
  output logic                      busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     gnt_id;
  logic [DATA_W-1:0]   data_r;
  logic [15:0]         lfsr;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    ones_acc;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                found;
  logic [DATA_W-1:0]   data_sel;
  logic                cmp;
  logic [15:0]         lfsr_next;

  // The compare sees the current LFSR value, so the first pulse of a stream
  // is always decided against SEED itself.
  assign cmp       = (data_r > lfsr);
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign busy      = (state == RUN);
  assign req_ready = (state == IDLE) ? grant : '0;

  // Round-robin search: the first valid requester after rr_ptr wins.
  // The outer loop walks priority order, the inner loop maps the rotated
  // position back to a constant index so no variable bit-select is needed.
  always_comb begin
    int pos;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    pos      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == pos) && req_valid[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          grant_id = ID_W'(j);
        end
      end
    end
  end

  // Select the binary value of the granted requester for latching.
  always_comb begin
    data_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) data_sel = req_data[j*DATA_W +: DATA_W];
    end
  end

  // Main FSM: IDLE grants and seeds the stream, RUN emits one registered
  // pulse per cycle and closes the stream on the final count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      gnt_id      <= '0;
      data_r      <= '0;
      lfsr        <= SEED;
      cnt         <= '0;
      ones_acc    <= '0;
      pulse_out   <= 1'b0;
      pulse_valid <= 1'b0;
      pulse_id    <= '0;
      pulse_last  <= 1'b0;
      done_valid  <= 1'b0;
      ones_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          pulse_out   <= 1'b0;
          pulse_valid <= 1'b0;
          pulse_id    <= '0;
          pulse_last  <= 1'b0;
          done_valid  <= 1'b0;
          if (found) begin
            data_r   <= data_sel;
            gnt_id   <= grant_id;
            rr_ptr   <= grant_id;
            lfsr     <= SEED;
            cnt      <= '0;
            ones_acc <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          pulse_out   <= cmp;
          pulse_valid <= 1'b1;
          pulse_id    <= gnt_id;
          ones_acc    <= ones_acc + CNT_W'(cmp);
          lfsr        <= lfsr_next;
          cnt         <= cnt + 1'b1;
          if (cnt == CNT_W'(STREAM_LEN - 1)) begin
            // Final pulse: the IDLE cycle that follows is where the next
            // grant can already be issued.
            pulse_last <= 1'b1;
            done_valid <= 1'b1;
            ones_count <= ones_acc + CNT_W'(cmp);
            state      <= IDLE;
          end else begin
            pulse_last <= 1'b0;
            done_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_b2p_arbiter.sv
// Self-checking bench for sc_b2p_arbiter: table of single-request streams
// followed by hand-written round-robin, mid-stream reset and back-to-back
// sequences. Expected pulses come from a reference LFSR/compare model.
`timescale 1ns/1ps
module tb_sc_b2p_arbiter;
  localparam int          NUM_REQ    = 4;
  localparam int          DATA_W     = 16;
  localparam int          STREAM_LEN = 256;
  localparam int          CNT_W      = 9;
  localparam int          ID_W       = 2;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      pulse_out;
  logic                      pulse_valid;
  logic [ID_W-1:0]           pulse_id;
  logic                      pulse_last;
  logic                      done_valid;
  logic [CNT_W-1:0]          ones_count;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_b2p_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .STREAM_LEN(STREAM_LEN),
    .CNT_W(CNT_W), .ID_W(ID_W), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pulse_out(pulse_out), .pulse_valid(pulse_valid),
    .pulse_id(pulse_id), .pulse_last(pulse_last), .done_valid(done_valid),
    .ones_count(ones_count), .busy(busy)
  );

  typedef struct {
    int          req;
    logic [15:0] data;
    int          exp_first;  // hand-computed first pulse
    int          exp_ones;   // hand-computed ones count, -1 when not hand-known
  } vec_t;

  vec_t tab[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference stream: compare against the LFSR, which starts at SEED.
  function automatic logic [STREAM_LEN-1:0] model_bits(input logic [15:0] d);
    logic [15:0] l;
    logic [STREAM_LEN-1:0] b;
    l = SEED;
    b = '0;
    for (int i = 0; i < STREAM_LEN; i++) begin
      b[i] = (d > l);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return b;
  endfunction

  function automatic int popcnt(input logic [STREAM_LEN-1:0] b);
    int n;
    n = 0;
    for (int i = 0; i < STREAM_LEN; i++) n += int'(b[i]);
    return n;
  endfunction

  // Waits (bounded) for any grant, checks it, then steps past the accept edge.
  task automatic wait_grant(input logic [3:0] exp_ready, input string name);
    int n;
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      tick();
      n++;
    end
    check(name, req_ready, exp_ready);
    tick();
  endtask

  // Called in the cycle right after the accept edge; observes the whole stream
  // and returns in the cycle after pulse_last.
  task automatic capture(input logic [15:0] d, input int id, input int exp_first,
                         input int exp_ones, input bit scramble,
                         input logic [3:0] exp_next_ready,
                         output logic [STREAM_LEN-1:0] bits);
    logic [STREAM_LEN-1:0] expb;
    int pv_n, bad_bits, bad_id, last_n, done_n, rep;
    bit last_end, done_end;
    logic [3:0] rdy;
    expb = model_bits(d);
    pv_n = 0; bad_bits = 0; bad_id = 0; last_n = 0; done_n = 0; rep = 0;
    last_end = 1'b0; done_end = 1'b0; rdy = '0; bits = '0;
    check("t1_pulse_valid", pulse_valid, 1'b0);
    check("t1_busy", busy, 1'b1);
    check("t1_ready", req_ready, 4'b0);
    tick();
    for (int i = 0; i < STREAM_LEN; i++) begin
      if (scramble && i == 100) begin
        req_data[16 +: 16] = 16'h4321;
        req_data[48 +: 16] = 16'h0001;
      end
      if (pulse_valid) pv_n++;
      bits[i] = pulse_out;
      if (pulse_out !== expb[i]) bad_bits++;
      if (pulse_id !== ID_W'(id)) bad_id++;
      if (pulse_last) begin last_n++; if (i == STREAM_LEN-1) last_end = 1'b1; end
      if (done_valid) begin done_n++; if (i == STREAM_LEN-1) done_end = 1'b1; end
      if (i == STREAM_LEN-1) begin
        rep = int'(ones_count);
        rdy = req_ready;
      end
      tick();
    end
    check("pulse_valid_len", pv_n, STREAM_LEN);
    check("stream_bits", bad_bits, 0);
    check("stream_id", bad_id, 0);
    check("last_count", last_n, 1);
    check("last_at_end", last_end, 1'b1);
    check("done_count", done_n, 1);
    check("done_at_end", done_end, 1'b1);
    check("ones_model", rep, popcnt(expb));
    check("ones_observed", rep, popcnt(bits));
    if (exp_first >= 0) check("first_pulse", bits[0], exp_first);
    if (exp_ones >= 0) check("ones_hand", rep, exp_ones);
    check("next_ready", rdy, exp_next_ready);
    $display("stream id=%0d data=%h ones=%0d first=%0b", id, d, rep, bits[0]);
  endtask

  initial begin
    logic [STREAM_LEN-1:0] bits, prev_bits;
    int n, guard, dn, last_ones;

    tab[0] = '{req: 0, data: 16'hACE2, exp_first: 1, exp_ones: -1};
    tab[1] = '{req: 1, data: 16'hACE1, exp_first: 0, exp_ones: -1};
    tab[2] = '{req: 0, data: 16'h0000, exp_first: 0, exp_ones: 0};
    tab[3] = '{req: 3, data: 16'h8000, exp_first: 0, exp_ones: -1};
    tab[4] = '{req: 3, data: 16'h8000, exp_first: 0, exp_ones: -1};
    tab[5] = '{req: 2, data: 16'hFFFF, exp_first: 1, exp_ones: -1};

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    prev_bits = '0;
    repeat (3) tick();
    check("rst_pulse_valid", pulse_valid, 1'b0);
    check("rst_pulse_out", pulse_out, 1'b0);
    check("rst_pulse_id", pulse_id, 2'b0);
    check("rst_pulse_last", pulse_last, 1'b0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_ones_count", ones_count, 9'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 4'b0);
    rst = 1'b0;
    tick();

    // Single-requester streams from the table.
    for (int i = 0; i < 6; i++) begin
      req_valid = '0;
      req_valid[tab[i].req] = 1'b1;
      req_data[tab[i].req*16 +: 16] = tab[i].data;
      wait_grant(4'(1 << tab[i].req), "grant_single");
      req_valid = '0;
      capture(tab[i].data, tab[i].req, tab[i].exp_first, tab[i].exp_ones, 1'b0, 4'b0, bits);
      if (i > 0 && tab[i].data == tab[i-1].data) check("repeat_bits", (bits === prev_bits), 1'b1);
      check("idle_pulse_valid", pulse_valid, 1'b0);
      check("idle_pulse_out", pulse_out, 1'b0);
      check("idle_pulse_id", pulse_id, 2'b0);
      last_ones = popcnt(model_bits(tab[i].data));
      tick();
      check("ones_hold", ones_count, last_ones);
      prev_bits = bits;
    end

    // Round-robin after a grant to requester 2; data changes during RUN are ignored.
    req_data[32 +: 16] = 16'h5A5A;
    req_valid = 4'b0100;
    wait_grant(4'b0100, "grant_rr2");
    req_valid = '0;
    capture(16'h5A5A, 2, 0, -1, 1'b0, 4'b0, bits);
    req_data[16 +: 16] = 16'h1234;
    req_data[48 +: 16] = 16'hACE2;
    req_valid = 4'b1010;
    wait_grant(4'b1000, "grant_rr3_first");
    req_valid = 4'b0010;
    capture(16'hACE2, 3, 1, -1, 1'b1, 4'b0010, bits);
    req_valid = '0;
    capture(16'h4321, 1, 0, -1, 1'b0, 4'b0, bits);
    tick();

    // Asynchronous reset at pulse 100 of a stream granted to requester 0.
    req_data[0 +: 16] = 16'hFFFF;
    req_valid = 4'b0001;
    wait_grant(4'b0001, "grant_pre_reset");
    req_valid = '0;
    n = 0;
    guard = 0;
    while (n < 100 && guard < 400) begin
      tick();
      guard++;
      if (pulse_valid) n++;
    end
    check("reached_pulse_100", n, 100);
    #2 rst = 1'b1;
    #1;
    check("arst_pulse_valid", pulse_valid, 1'b0);
    check("arst_pulse_out", pulse_out, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ones_count", ones_count, 9'd0);
    check("arst_done_valid", done_valid, 1'b0);
    dn = 0;
    repeat (3) begin
      tick();
      if (done_valid || pulse_last) dn++;
    end
    check("no_done_in_reset", dn, 0);
    rst = 1'b0;
    req_valid = 4'b0011;
    #1 check("rr_ptr_after_reset", req_ready, 4'b0001);
    req_data[16 +: 16] = 16'hACE2;
    req_valid = 4'b0010;
    #1 check("withdraw_req0", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    capture(16'hACE2, 1, 1, -1, 1'b0, 4'b0, bits);

    // All requesters held from reset: grants 0,1,2,3,0,1 back to back.
    tick();
    rst = 1'b1;
    req_data = {16'h0000, 16'hFFFF, 16'h8000, 16'hACE2};
    req_valid = 4'b1111;
    repeat (2) tick();
    rst = 1'b0;
    wait_grant(4'b0001, "grant_all_first");
    capture(16'hACE2, 0, 1, -1, 1'b0, 4'b0010, bits);
    capture(16'h8000, 1, 0, -1, 1'b0, 4'b0100, bits);
    capture(16'hFFFF, 2, 1, -1, 1'b0, 4'b1000, bits);
    capture(16'h0000, 3, 0, 0, 1'b0, 4'b0001, bits);
    capture(16'hACE2, 0, 1, -1, 1'b0, 4'b0010, bits);
    req_valid = '0;
    capture(16'h8000, 1, 0, -1, 1'b0, 4'b0, bits);
    check("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
